// File: rtl/result_serializer.sv
// result_serializer: buffers stored core result vectors in a small FIFO and streams them out as OUT_W-bit words.
// Define RESULT_SERIALIZER_MSB_FIRST_EN to transmit the most significant word of each vector first.
module result_serializer #(
   parameter int unsigned DIM   = 1023,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             store,
   input  logic [DIM:0]     core_result,
   input  logic             last,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             full,
   output logic             overflow,
   output logic             done
);

   localparam int unsigned VEC_W = DIM + 1;
   localparam int unsigned WORDS = VEC_W / OUT_W;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   mem_q [DEPTH];
   logic [VEC_W-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0]   tag_q, tag_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   rd_nxt;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   idx_inc;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;
   logic               done_seen_q, done_seen_d;
   logic               push_req, accept, pop;

   // Selects transmitted word k of a vector in the configured word order.
   function automatic logic [OUT_W-1:0] word_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [IDX_W-1:0] k);
      logic [OUT_W-1:0] w;
      w = '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (k == IDX_W'(i)) begin
`ifdef RESULT_SERIALIZER_MSB_FIRST_EN
            w = vec[(WORDS-1-i)*OUT_W +: OUT_W];
`else
            w = vec[i*OUT_W +: OUT_W];
`endif
         end
      end
      return w;
   endfunction

   assign rd_nxt  = rd_ptr_q + PTR_W'(1);
   assign idx_inc = idx_q + IDX_W'(1);

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      tag_d       = tag_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      overflow_d  = overflow_q;
      done_d      = done_q;
      done_seen_d = done_seen_q;
      pop         = 1'b0;
      push_req    = store & ~done_seen_q;
      accept      = 1'b0;

      case (state_q)
         S_IDLE: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            if (count_q != '0) begin
               state_d     = S_SEND;
               idx_d       = '0;
               out_valid_d = 1'b1;
               out_data_d  = word_sel(mem_q[rd_ptr_q], '0);
               out_last_d  = (LAST_IDX == '0) & tag_q[rd_ptr_q];
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (idx_q != LAST_IDX) begin
                  idx_d      = idx_inc;
                  out_data_d = word_sel(mem_q[rd_ptr_q], idx_inc);
                  out_last_d = (idx_inc == LAST_IDX) & tag_q[rd_ptr_q];
               end else begin
                  pop   = 1'b1;
                  idx_d = '0;
                  if (tag_q[rd_ptr_q]) begin
                     state_d     = S_DONE;
                     out_valid_d = 1'b0;
                     out_last_d  = 1'b0;
                     out_data_d  = '0;
                     done_d      = 1'b1;
                  end else if (count_q > CNT_W'(1)) begin
                     // Next entry already resident: continue without a bubble.
                     out_data_d = word_sel(mem_q[rd_nxt], '0);
                     out_last_d = (LAST_IDX == '0) & tag_q[rd_nxt];
                  end else begin
                     state_d     = S_IDLE;
                     out_valid_d = 1'b0;
                     out_last_d  = 1'b0;
                     out_data_d  = '0;
                  end
               end
            end
         end
         S_DONE: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A full FIFO still takes a strobe when the head retires in the same cycle.
      accept     = push_req & ((count_q != DEPTH_CNT) | pop);
      overflow_d = overflow_q | (push_req & ~accept);
      if (accept) begin
         mem_d[wr_ptr_q] = core_result;
         tag_d[wr_ptr_q] = last;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         if (last) begin
            done_seen_d = 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_nxt;
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

      if (!run) begin
         state_d     = S_IDLE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         idx_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_last_d  = 1'b0;
         overflow_d  = 1'b0;
         done_d      = 1'b0;
         done_seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tag_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         done_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         done_seen_q <= done_seen_d;
      end
   end

   // Vector storage is pure datapath; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;
   assign done      = done_q;
   assign full      = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus randomized traffic against a word-stream reference queue.
module tb_result_serializer;

   localparam int unsigned DIM   = 127;
   localparam int unsigned OUT_W = 32;
   localparam int unsigned DEPTH = 2;
   localparam int          WORDS = 4;

   logic             clk = 1'b0;
   logic             rst, run, store, last, out_ready;
   logic [DIM:0]     core_result;
   logic             out_valid, out_last, full, overflow, done;
   logic [OUT_W-1:0] out_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [OUT_W:0] exp_q[$];
   logic [OUT_W:0] got_q[$];

   always #5 clk = ~clk;

   result_serializer #(.DIM(DIM), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .run(run), .store(store), .core_result(core_result), .last(last),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .full(full), .overflow(overflow), .done(done)
   );

   // Sink side: record every word the sink accepts at the following rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [OUT_W-1:0] ref_word(input logic [DIM:0] v, input int k);
`ifdef RESULT_SERIALIZER_MSB_FIRST_EN
      return v[(WORDS-1-k)*OUT_W +: OUT_W];
`else
      return v[k*OUT_W +: OUT_W];
`endif
   endfunction

   function automatic logic [DIM:0] rand_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [DIM:0] v, input logic lt);
      for (int k = 0; k < WORDS; k++) exp_q.push_back({lt && (k == WORDS-1), ref_word(v, k)});
   endtask

   task automatic strobe(input logic [DIM:0] v, input logic lt);
      store = 1'b1; core_result = v; last = lt;
      tick();
      store = 1'b0; last = 1'b0;
   endtask

   task automatic drain(input int budget);
      out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (got_q.size() >= exp_q.size() && !out_valid) break;
         tick();
      end
      check("drain_idle", 128'(out_valid), 128'(0));
   endtask

   task automatic wait_word(input string tag, input logic [OUT_W-1:0] w, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid && out_data === w) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check(tag, 128'(found), 128'(1));
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [DIM:0] v, a, b, c, d, e, f;
      bit           hit;

      rst = 1'b1; run = 1'b0; store = 1'b0; last = 1'b0; core_result = '0; out_ready = 1'b1;
      #12;
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_data",  128'(out_data),  128'(0));
      check("rst_last",  128'(out_last),  128'(0));
      check("rst_full",  128'(full),      128'(0));
      check("rst_ovf",   128'(overflow),  128'(0));
      check("rst_done",  128'(done),      128'(0));
      @(posedge clk); #1;
      rst = 1'b0; run = 1'b1;
      tick();

      // Single vector, latency and word order
      v = 128'h0123456789ABCDEF0123456789ABCDEF;
      model_push(v, 1'b0);
      strobe(v, 1'b0);
      check("lat_early_valid", 128'(out_valid), 128'(0));
      tick();
      check("lat_valid", 128'(out_valid), 128'(1));
      check("lat_word0", 128'(out_data), 128'(ref_word(v, 0)));
      drain(50);
      check("single_done", 128'(done), 128'(0));
      check("single_full", 128'(full), 128'(0));
      compare_stream("single");

      // Backpressure at word index 2
      v = rand_vec();
      model_push(v, 1'b0);
      strobe(v, 1'b0);
      wait_word("bp_reach_w2", ref_word(v, 2), 20);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 128'(out_valid), 128'(1));
         check("bp_data", 128'(out_data), 128'(ref_word(v, 2)));
      end
      drain(50);
      compare_stream("backpressure");

      // Overflow: third strobe into a full FIFO is dropped
      out_ready = 1'b0;
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_push(a, 1'b0);
      model_push(b, 1'b0);
      strobe(a, 1'b0);
      strobe(b, 1'b0);
      check("ovf_full", 128'(full), 128'(1));
      check("ovf_pre", 128'(overflow), 128'(0));
      strobe(c, 1'b0);
      check("ovf_set", 128'(overflow), 128'(1));
      check("ovf_full2", 128'(full), 128'(1));
      tick(); tick();
      check("ovf_stalled", 128'(got_q.size()), 128'(0));
      drain(60);
      check("ovf_sticky", 128'(overflow), 128'(1));
      compare_stream("overflow");
      run = 1'b0;
      tick();
      check("ovf_clear", 128'(overflow), 128'(0));
      run = 1'b1;
      tick();

      // Push into a full FIFO on the cycle the head's final word retires
      out_ready = 1'b0;
      d = 128'h44444444_33333333_22222222_11111111;
      e = rand_vec(); f = rand_vec();
      model_push(d, 1'b0);
      model_push(e, 1'b0);
      model_push(f, 1'b0);
      strobe(d, 1'b0);
      strobe(e, 1'b0);
      check("fp_full_pre", 128'(full), 128'(1));
      out_ready = 1'b1;
      wait_word("fp_reach_w3", ref_word(d, WORDS-1), 20);
      store = 1'b1; core_result = f;
      tick();
      store = 1'b0;
      check("fp_full", 128'(full), 128'(1));
      check("fp_ovf", 128'(overflow), 128'(0));
      drain(80);
      compare_stream("full_pop");

      // Last-tagged vector, done, then ignored strobes
      v = rand_vec();
      model_push(v, 1'b1);
      strobe(v, 1'b1);
      for (int i = 0; i < 30; i++) begin
         if (got_q.size() >= exp_q.size()) break;
         tick();
      end
      check("last_done", 128'(done), 128'(1));
      check("last_valid", 128'(out_valid), 128'(0));
      compare_stream("last");
      strobe(rand_vec(), 1'b0);
      tick(); tick(); tick();
      check("ign_ovf", 128'(overflow), 128'(0));
      check("ign_done", 128'(done), 128'(1));
      check("ign_valid", 128'(out_valid), 128'(0));
      check("ign_words", 128'(got_q.size()), 128'(0));
      run = 1'b0;
      tick();
      check("run_clr_done", 128'(done), 128'(0));
      run = 1'b1;
      tick();

      // Flush while word 1 is presented
      v = rand_vec();
      exp_q.push_back({1'b0, ref_word(v, 0)});
      strobe(v, 1'b0);
      wait_word("fl_reach_w1", ref_word(v, 1), 20);
      run = 1'b0; out_ready = 1'b0;
      tick();
      check("fl_valid", 128'(out_valid), 128'(0));
      check("fl_full", 128'(full), 128'(0));
      run = 1'b1; out_ready = 1'b1;
      tick(); tick(); tick();
      check("fl_empty", 128'(out_valid), 128'(0));
      compare_stream("flush");

      // Asynchronous reset while sending, with full and overflow set
      out_ready = 1'b0;
      strobe(rand_vec(), 1'b0);
      strobe(rand_vec(), 1'b0);
      strobe(rand_vec(), 1'b0);
      check("ar_pre_valid", 128'(out_valid), 128'(1));
      check("ar_pre_ovf", 128'(overflow), 128'(1));
      #1 rst = 1'b1;
      #1;
      check("ar_valid", 128'(out_valid), 128'(0));
      check("ar_data",  128'(out_data),  128'(0));
      check("ar_last",  128'(out_last),  128'(0));
      check("ar_full",  128'(full),      128'(0));
      check("ar_ovf",   128'(overflow),  128'(0));
      check("ar_done",  128'(done),      128'(0));
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      tick();
      compare_stream("arst");

      // Randomized traffic with random sink stalls; strobes only when space is visible
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = ($urandom_range(3) != 0);
         hit = ($urandom_range(2) == 0);
         if (!full && hit) begin
            v = rand_vec();
            model_push(v, 1'b0);
            store = 1'b1; core_result = v;
         end else begin
            store = 1'b0;
         end
         tick();
      end
      store = 1'b0;
      drain(300);
      check("rnd_ovf", 128'(overflow), 128'(0));
      compare_stream("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
